// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined integer ALU: decode packet, pipe entry, depth limits.
// Fields are sized for the widest datapath; narrower instances use the low XLEN bits.
package alu_pipe_pkg;

    localparam int ALU_PIPE_MAX_STAGES = 4;
    localparam int ALU_PIPE_MIN_STAGES = 1;
    localparam int ALU_MAX_XLEN        = 64;
    localparam int ALU_MAX_SHW         = 6;

    typedef logic [ALU_MAX_XLEN-1:0] xword_t;

    // One op flag is set per instruction; slt/sltu arrive with sub=1 so the adder compares.
    typedef struct packed {
        xword_t                 rs1_data;
        xword_t                 rs2_data;
        xword_t                 imm;
        logic                   imm_valid;
        logic [ALU_MAX_SHW-1:0] shamt;
        logic                   shimm5;
        logic                   op_add;
        logic                   op_slt;
        logic                   op_and;
        logic                   op_or;
        logic                   op_xor;
        logic                   op_sll;
        logic                   op_srl;
        logic                   op_sra;
        logic                   sub;
        logic                   unsign;
        logic                   rd;
        logic                   legal;
        logic                   alu;
        logic                   nop;
        logic [4:0]             rd_addr;
        xword_t                 instr_tag;
        logic [31:0]            instr;
    } idu1_out_t;

    typedef struct packed {
        logic        valid;
        xword_t      data;
        logic [4:0]  rd_addr;
        logic        wr_en;
        xword_t      tag;
        logic [31:0] instr;
    } alu_pipe_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I/RV64I ALU op evaluation and register write-enable decode.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipe decides when the result is captured.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  idu1_out_t        ctrl,
    output logic [XLEN-1:0]  result,
    output logic             wr_en
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] bx;
    logic [XLEN:0]   sum;
    logic [SHW-1:0]  sh;
    logic            cout;
    logic            neg;
    logic            ov;
    logic            lt;

    assign a = ctrl.rs1_data[XLEN-1:0];

    always_comb begin
        b = ctrl.rs2_data[XLEN-1:0];
        if (ctrl.imm_valid) begin
            b = ctrl.imm[XLEN-1:0];
        end else if (ctrl.shimm5) begin
            b = {{(XLEN-SHW){1'b0}}, ctrl.shamt[SHW-1:0]};
        end
    end

    // Single XLEN+1 adder serves add, sub and both compares; sub inverts b and supplies carry-in.
    assign bx   = ctrl.sub ? ~b : b;
    assign sum  = {1'b0, a} + {1'b0, bx} + {{XLEN{1'b0}}, ctrl.sub};
    assign cout = sum[XLEN];
    assign neg  = sum[XLEN-1];
    assign ov   = (a[XLEN-1] == bx[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
    assign lt   = ctrl.unsign ? ~cout : (neg ^ ov);
    assign sh   = b[SHW-1:0];

    always_comb begin
        result = '0;
        if (ctrl.op_add) result = result | sum[XLEN-1:0];
        if (ctrl.op_slt) result = result | {{(XLEN-1){1'b0}}, lt};
        if (ctrl.op_and) result = result | (a & b);
        if (ctrl.op_or)  result = result | (a | b);
        if (ctrl.op_xor) result = result | (a ^ b);
        if (ctrl.op_sll) result = result | (a << sh);
        if (ctrl.op_srl) result = result | (a >> sh);
        if (ctrl.op_sra) result = result | $unsigned($signed(a) >>> sh);
    end

    assign wr_en = ctrl.rd & ctrl.legal & ctrl.alu & ~ctrl.nop & (ctrl.rd_addr != 5'd0);

    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl.instr_tag, ctrl.instr};

    if (XLEN < ALU_MAX_XLEN) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{ctrl.rs1_data[ALU_MAX_XLEN-1:XLEN], ctrl.rs2_data[ALU_MAX_XLEN-1:XLEN],
                             ctrl.imm[ALU_MAX_XLEN-1:XLEN], ctrl.shamt[ALU_MAX_SHW-1:SHW]};
    end

endmodule

// File: rtl/dff_rst.sv
// Generic register with load enable and synchronous active-low clear.
// Latency: 1 cycle from d to q when en=1.
// Backpressure: none; the owner holds state by dropping en.
module dff_rst #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer ALU between IDU1 issue and the writeback arbiter.
// Latency: STAGES cycles accept-to-out_valid, 1 op/cycle throughput.
// Backpressure: a valid, unconsumed tail stalls every stage; flush kills all in-flight ops.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  idu1_out_t        alu_ctrl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_wb_data,
    output logic [4:0]       alu_wb_rd_addr,
    output logic             alu_wb_rd_wr_en,
    output logic [XLEN-1:0]  instr_tag_out,
    output logic [31:0]      instr_out
);

    localparam int EW = $bits(alu_pipe_entry_t);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("alu_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < ALU_PIPE_MIN_STAGES || STAGES > ALU_PIPE_MAX_STAGES) begin : g_bad_stages
        $error("alu_pipe: STAGES must be within 1..4");
    end

    logic [XLEN-1:0]  core_result;
    logic             core_wr_en;
    logic             adv;
    logic             accept;
    alu_pipe_entry_t  head;
    alu_pipe_entry_t  tail;
    alu_pipe_entry_t  st_q [STAGES];

    alu_core #(.XLEN(XLEN)) u_core (
        .ctrl   (alu_ctrl),
        .result (core_result),
        .wr_en  (core_wr_en)
    );

    assign tail     = st_q[STAGES-1];
    assign adv      = ~tail.valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & in_ready;

    always_comb begin
        head                = '0;
        head.valid          = accept;
        head.data[XLEN-1:0] = core_result;
        head.rd_addr        = alu_ctrl.rd_addr;
        head.wr_en          = core_wr_en;
        head.tag            = alu_ctrl.instr_tag;
        head.instr          = alu_ctrl.instr;
    end

    // Payload only moves with a valid op, so bubbles and flushes leave the outputs untouched.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        alu_pipe_entry_t inc;
        alu_pipe_entry_t d;
        alu_pipe_entry_t q;

        if (i == 0) begin : g_head
            assign inc = head;
        end else begin : g_body
            assign inc = st_q[i-1];
        end

        always_comb begin
            d = q;
            if (adv && inc.valid) begin
                d = inc;
            end
            d.valid = ~flush & (adv ? inc.valid : q.valid);
        end

        dff_rst #(.W(EW)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv | flush),
            .d     (d),
            .q     (q)
        );

        assign st_q[i] = q;
    end

    assign out_valid       = tail.valid;
    assign alu_wb_data     = tail.data[XLEN-1:0];
    assign alu_wb_rd_addr  = tail.rd_addr;
    assign alu_wb_rd_wr_en = tail.valid & tail.wr_en;
    assign instr_tag_out   = tail.tag[XLEN-1:0];
    assign instr_out       = tail.instr;

    if (XLEN < ALU_MAX_XLEN) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{tail.data[ALU_MAX_XLEN-1:XLEN], tail.tag[ALU_MAX_XLEN-1:XLEN]};
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a 32-bit/2-stage and a 64-bit/3-stage instance against a
// plain-arithmetic reference model and an in-order expected-result queue per instance.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] tag;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv   [2];
    logic        ir   [2];
    logic        fl   [2];
    logic        ov   [2];
    logic        ordy [2];
    idu1_out_t   ctrl [2];
    logic [63:0] data [2];
    logic [63:0] tag  [2];
    logic [4:0]  rd   [2];
    logic        we   [2];
    logic [31:0] instr [2];
    logic [31:0] data32;
    logic [31:0] tag32;
    logic [63:0] data64;
    logic [63:0] tag64;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int popped [2];

    exp_t         exp_q [2][$];
    logic         prev_stall [2];
    logic [127:0] prev_a [2];
    logic [38:0]  prev_b [2];

    always #5 clk = ~clk;

    alu_pipe #(.XLEN(32), .STAGES(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .alu_ctrl(ctrl[0]),
        .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .alu_wb_data(data32),
        .alu_wb_rd_addr(rd[0]), .alu_wb_rd_wr_en(we[0]), .instr_tag_out(tag32), .instr_out(instr[0])
    );

    alu_pipe #(.XLEN(64), .STAGES(3)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .alu_ctrl(ctrl[1]),
        .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .alu_wb_data(data64),
        .alu_wb_rd_addr(rd[1]), .alu_wb_rd_wr_en(we[1]), .instr_tag_out(tag64), .instr_out(instr[1])
    );

    assign data[0] = {32'd0, data32};
    assign tag[0]  = {32'd0, tag32};
    assign data[1] = data64;
    assign tag[1]  = tag64;

    task automatic check(string name, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference: RISC-V ALU semantics written directly as integer arithmetic on an xlen-bit word.
    function automatic exp_t model(idu1_out_t c, int xlen);
        exp_t        e;
        logic [63:0] m, a, b, sa, sbv, r;
        int          sh;
        m = (xlen == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        a = c.rs1_data & m;
        if (c.imm_valid)   b = c.imm & m;
        else if (c.shimm5) b = 64'(c.shamt) & 64'(xlen - 1);
        else               b = c.rs2_data & m;
        sh  = int'(b & 64'(xlen - 1));
        sa  = (xlen == 64) ? a : {{32{a[31]}}, a[31:0]};
        sbv = (xlen == 64) ? b : {{32{b[31]}}, b[31:0]};
        r = 64'd0;
        if (c.op_add) r = c.sub ? a - b : a + b;
        if (c.op_slt) r = (c.unsign ? (a < b) : ($signed(sa) < $signed(sbv))) ? 64'd1 : 64'd0;
        if (c.op_and) r = a & b;
        if (c.op_or)  r = a | b;
        if (c.op_xor) r = a ^ b;
        if (c.op_sll) r = a << sh;
        if (c.op_srl) r = a >> sh;
        if (c.op_sra) r = $signed(sa) >>> sh;
        e.data  = r & m;
        e.rd    = c.rd_addr;
        e.we    = c.rd && c.legal && c.alu && !c.nop && (c.rd_addr != 5'd0);
        e.tag   = c.instr_tag & m;
        e.instr = c.instr;
        return e;
    endfunction

    // op: 0 add 1 sub 2 slt 3 sltu 4 and 5 or 6 xor 7 sll 8 srl 9 sra, anything else no op flag
    function automatic idu1_out_t rand_ctrl(int op);
        idu1_out_t c = '0;
        c.rs1_data  = {$urandom, $urandom};
        c.rs2_data  = {$urandom, $urandom};
        c.imm       = {$urandom, $urandom};
        c.imm_valid = ($urandom_range(0, 3) == 0);
        c.shamt     = 6'($urandom);
        c.shimm5    = !c.imm_valid && ($urandom_range(0, 2) == 0);
        case (op)
            0: c.op_add = 1'b1;
            1: begin c.op_add = 1'b1; c.sub = 1'b1; end
            2: begin c.op_slt = 1'b1; c.sub = 1'b1; end
            3: begin c.op_slt = 1'b1; c.sub = 1'b1; c.unsign = 1'b1; end
            4: c.op_and = 1'b1;
            5: c.op_or  = 1'b1;
            6: c.op_xor = 1'b1;
            7: c.op_sll = 1'b1;
            8: c.op_srl = 1'b1;
            9: c.op_sra = 1'b1;
            default: c.sub = 1'($urandom);
        endcase
        c.rd        = ($urandom_range(0, 7) != 0);
        c.legal     = ($urandom_range(0, 7) != 0);
        c.alu       = ($urandom_range(0, 7) != 0);
        c.nop       = ($urandom_range(0, 7) == 0);
        c.rd_addr   = 5'($urandom);
        c.instr_tag = {$urandom, $urandom};
        c.instr     = $urandom;
        return c;
    endfunction

    function automatic idu1_out_t en_wr(idu1_out_t c, logic [4:0] addr);
        idu1_out_t r = c;
        r.rd = 1'b1; r.legal = 1'b1; r.alu = 1'b1; r.nop = 1'b0; r.rd_addr = addr;
        return r;
    endfunction

    task automatic mon(int k);
        exp_t e;
        if (!rst_n) begin
            exp_q[k].delete();
            prev_stall[k] <= 1'b0;
        end else begin
            if (prev_stall[k]) begin
                check("stall_hold_dat", {data[k], tag[k]}, prev_a[k]);
                check("stall_hold_ctl", 128'({instr[k], rd[k], we[k], ov[k]}), 128'(prev_b[k]));
            end
            if (ov[k] && ordy[k]) begin
                check("tail_expected", 128'(exp_q[k].size() != 0), 128'd1);
                if (exp_q[k].size() != 0) begin
                    e = exp_q[k].pop_front();
                    check("sb_data", 128'(data[k]), 128'(e.data));
                    check("sb_meta", 128'({tag[k], instr[k], rd[k], we[k]}),
                          128'({e.tag, e.instr, e.rd, e.we}));
                    popped[k] <= popped[k] + 1;
                end
            end
            if (fl[k]) exp_q[k].delete();
            else if (iv[k] && ir[k]) exp_q[k].push_back(model(ctrl[k], (k == 0) ? 32 : 64));
            prev_stall[k] <= ov[k] & ~ordy[k] & ~fl[k];
            prev_a[k]     <= {data[k], tag[k]};
            prev_b[k]     <= {instr[k], rd[k], we[k], ov[k]};
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idu1_out_t c;
        idu1_out_t ops [4];
        int        idx;
        int        p0;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; fl[k] = 1'b0; ctrl[k] = '0;
            popped[k] = 0; prev_stall[k] = 1'b0; prev_a[k] = '0; prev_b[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_out_valid", 128'(ov[k]), 128'd0);
            check("rst_in_ready", 128'(ir[k]), 128'd1);
            check("rst_data", 128'(data[k]), 128'd0);
            check("rst_meta", 128'({tag[k], instr[k], rd[k], we[k]}), 128'd0);
        end

        // add latency and signed overflow wrap, 32-bit/2-stage
        cyc();
        c = en_wr(rand_ctrl(0), 5'd7);
        c.rs1_data = 64'h0000_0000_7FFF_FFFF; c.imm = 64'd1; c.imm_valid = 1'b1; c.shimm5 = 1'b0;
        iv[0] = 1'b1; ctrl[0] = c;
        #1 check("t1_lat0", 128'(ov[0]), 128'd0);
        cyc(); iv[0] = 1'b0;
        #1 check("t1_lat1", 128'(ov[0]), 128'd0);
        cyc();
        #1 check("t1_lat2", 128'(ov[0]), 128'd1);
        check("t1_data", 128'(data[0]), 128'h8000_0000);
        check("t1_wren", 128'(we[0]), 128'd1);

        // slt / sltu / sra on the 64-bit/3-stage instance
        cyc();
        c = en_wr(rand_ctrl(2), 5'd1);
        c.rs1_data = {64{1'b1}}; c.rs2_data = 64'd1; c.imm_valid = 1'b0; c.shimm5 = 1'b0;
        iv[1] = 1'b1; ctrl[1] = c;
        cyc();
        c.unsign = 1'b1; ctrl[1] = c;
        cyc();
        c = en_wr(rand_ctrl(9), 5'd2);
        c.rs1_data = 64'h8000_0000_0000_0000; c.shamt = 6'd63; c.imm_valid = 1'b0; c.shimm5 = 1'b1;
        ctrl[1] = c;
        cyc(); iv[1] = 1'b0;
        #1 check("t2_slt", 128'(data[1]), 128'd1);
        check("t2_slt_valid", 128'(ov[1]), 128'd1);
        cyc();
        #1 check("t2_sltu", 128'(data[1]), 128'd0);
        cyc();
        #1 check("t2_sra", 128'(data[1]), 128'(64'hFFFF_FFFF_FFFF_FFFF));

        // backpressure: four ops, writeback stalled while the tail is valid
        for (int j = 0; j < 4; j++) ops[j] = en_wr(rand_ctrl($urandom_range(0, 9)), 5'(j + 3));
        idx = 0;
        p0  = popped[0];
        for (int n = 0; n < 40 && !(idx == 4 && exp_q[0].size() == 0); n++) begin
            cyc();
            ordy[0] = (n >= 5);
            iv[0]   = (idx < 4);
            if (idx < 4) ctrl[0] = ops[idx];
            #1;
            if (n >= 2 && n <= 4) check("t3_stall_in_ready", 128'(ir[0]), 128'd0);
            if (iv[0] && ir[0]) idx++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        check("t3_drained", 128'(idx == 4 && exp_q[0].size() == 0), 128'd1);
        check("t3_count", 128'(popped[0] - p0), 128'd4);

        // flush with a full 3-stage pipe and a new op presented while in_ready=1
        for (int j = 0; j < 3; j++) begin
            cyc();
            ordy[1] = 1'b0; iv[1] = 1'b1; ctrl[1] = rand_ctrl($urandom_range(0, 9));
        end
        cyc();
        ordy[1] = 1'b1; fl[1] = 1'b1; iv[1] = 1'b1; ctrl[1] = rand_ctrl(0);
        #1 check("t4_full", 128'(ov[1]), 128'd1);
        check("t4_in_ready", 128'(ir[1]), 128'd1);
        cyc(); fl[1] = 1'b0; iv[1] = 1'b0;
        #1 check("t4_flushed", 128'(ov[1]), 128'd0);
        for (int j = 0; j < 5; j++) begin
            cyc();
            #1 check("t4_no_ghost", 128'(ov[1]), 128'd0);
        end

        // rd_addr=0 and nop ops never write
        cyc();
        iv[0] = 1'b1; ctrl[0] = en_wr(rand_ctrl(0), 5'd0);
        cyc();
        c = en_wr(rand_ctrl(5), 5'd9); c.nop = 1'b1; ctrl[0] = c;
        cyc(); iv[0] = 1'b0;
        #1 check("t5_x0_valid", 128'(ov[0]), 128'd1);
        check("t5_x0_wren", 128'(we[0]), 128'd0);
        cyc();
        #1 check("t5_nop_valid", 128'(ov[0]), 128'd1);
        check("t5_nop_wren", 128'(we[0]), 128'd0);

        // one-cycle reset mid-stream with both pipes full
        for (int j = 0; j < 3; j++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                ordy[k] = 1'b0; iv[k] = 1'b1; ctrl[k] = rand_ctrl($urandom_range(0, 9));
            end
        end
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin iv[k] = 1'b0; ordy[k] = 1'b1; end
        #1;
        for (int k = 0; k < 2; k++) begin
            check("t6_out_valid", 128'(ov[k]), 128'd0);
            check("t6_in_ready", 128'(ir[k]), 128'd1);
            check("t6_data", 128'(data[k]), 128'd0);
            check("t6_meta", 128'({tag[k], instr[k], rd[k], we[k]}), 128'd0);
        end
        cyc();
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; ctrl[k] = en_wr(rand_ctrl($urandom_range(0, 9)), 5'd4);
        end
        cyc();
        for (int k = 0; k < 2; k++) iv[k] = 1'b0;
        #1 check("t6_lat1_32", 128'(ov[0]), 128'd0);
        check("t6_lat1_64", 128'(ov[1]), 128'd0);
        cyc();
        #1 check("t6_lat2_32", 128'(ov[0]), 128'd1);
        check("t6_lat2_64", 128'(ov[1]), 128'd0);
        cyc();
        #1 check("t6_lat3_64", 128'(ov[1]), 128'd1);

        // random traffic with random backpressure and occasional flush
        for (int n = 0; n < 400; n++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 9) < 7);
                ctrl[k] = rand_ctrl($urandom_range(0, 10));
                ordy[k] = ($urandom_range(0, 9) < 7);
                fl[k]   = ($urandom_range(0, 39) == 0);
            end
        end
        cyc();
        for (int k = 0; k < 2; k++) begin iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1; end
        repeat (8) cyc();
        for (int k = 0; k < 2; k++) begin
            check("rand_drained", 128'(exp_q[k].size()), 128'd0);
            check("rand_idle", 128'(ov[k]), 128'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
